// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbiter-multiplexer with one registered output stage.
// MODE 0 gives fixed priority (lowest index wins); MODE 1 gives round-robin from a rotating pointer.
module rr_arb_mux #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned MODE  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  int unsigned      base;

  assign accept = !out_valid || out_ready;

  // Two ascending passes: channels at or above the start point first, then the ones below it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    base    = (MODE == 1) ? 32'(ptr) : 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!gnt_any && in_valid[i] && (i >= base)) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!gnt_any && in_valid[i] && (i < base)) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        in_ready[i] = rst_n & accept & gnt_any;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The pointer wraps at NCH, not at 2**SEL_W.
  assign ptr_nxt = (gnt_idx == SEL_W'(NCH - 1)) ? '0 : gnt_idx + SEL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (accept) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= gnt_idx;
        if (MODE == 1) ptr <= ptr_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Table-driven bench: a round-robin and a fixed-priority instance share all inputs,
// plus hand-written sequences for backpressure and asynchronous reset.
module tb_rr_arb_mux;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned NCH   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       in_valid = '0;
  logic [NCH*WIDTH-1:0] in_data = '0;
  logic                 out_ready = 1'b0;

  logic [NCH-1:0]   rr_in_ready, fp_in_ready;
  logic             rr_out_valid, fp_out_valid;
  logic [WIDTH-1:0] rr_out_data, fp_out_data;
  logic [1:0]       rr_out_ch, fp_out_ch;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(2), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_ch(rr_out_ch), .out_ready(out_ready)
  );

  rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .SEL_W(2), .MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_ch(fp_out_ch), .out_ready(out_ready)
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rr_rdy;
    logic       rr_ov;
    logic [1:0] rr_ch;
    logic [3:0] fp_rdy;
    logic       fp_ov;
    logic [1:0] fp_ch;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [1:0] ch,
                         input logic [63:0] dat, input logic fp);
    if (fp) begin
      check({tag, " fp out_valid"}, 64'(fp_out_valid), 64'(ov));
      check({tag, " fp out_ch"},    64'(fp_out_ch),    64'(ch));
      check({tag, " fp out_data"},  fp_out_data,       dat);
    end else begin
      check({tag, " rr out_valid"}, 64'(rr_out_valid), 64'(ov));
      check({tag, " rr out_ch"},    64'(rr_out_ch),    64'(ch));
      check({tag, " rr out_data"},  rr_out_data,       dat);
    end
  endtask

  function automatic logic [63:0] chdat(input logic [1:0] ch);
    return 64'hA0 + 64'(ch);
  endfunction

  initial begin
    // T2: all valid, round-robin 0,1,2,3,0
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 4'h1, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 4'h1, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 4'h1, 1'b1, 2'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 4'h1, 1'b1, 2'd0};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 4'h1, 1'b1, 2'd0};
    // T3: ch2 moves ptr to 3; lone ch1 wins (ptr->2); then ch0+ch2 -> ch2
    tbl[5]  = '{4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 4'h4, 1'b1, 2'd2};
    tbl[6]  = '{4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 2'd1};
    tbl[7]  = '{4'h5, 1'b1, 4'h4, 1'b1, 2'd2, 4'h1, 1'b1, 2'd0};
    // T4: ch1+ch3 for 4 cycles; fixed priority always ch1, rr alternates
    tbl[8]  = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 4'h2, 1'b1, 2'd1};
    tbl[9]  = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 2'd1};
    tbl[10] = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd3, 4'h2, 1'b1, 2'd1};
    tbl[11] = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1, 4'h2, 1'b1, 2'd1};
    // T6: no request drains the stage; ptr stays at 2, so all-valid then picks ch2
    tbl[12] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 4'h0, 1'b0, 2'd1};
    tbl[13] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 4'h1, 1'b1, 2'd0};

    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 64'hA0 + 64'(i);

    repeat (2) @(negedge clk);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    check("initial reset in_ready", 64'(rr_in_ready), 64'h0);
    chk_out("initial reset", 1'b0, 2'd0, 64'h0, 1'b0);
    chk_out("initial reset", 1'b0, 2'd0, 64'h0, 1'b1);
    in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      in_valid  = tbl[v].vld;
      out_ready = tbl[v].ordy;
      #1;
      check($sformatf("v%0d rr in_ready", v), 64'(rr_in_ready), 64'(tbl[v].rr_rdy));
      check($sformatf("v%0d fp in_ready", v), 64'(fp_in_ready), 64'(tbl[v].fp_rdy));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", v), tbl[v].rr_ov, tbl[v].rr_ch, chdat(tbl[v].rr_ch), 1'b0);
      chk_out($sformatf("v%0d", v), tbl[v].fp_ov, tbl[v].fp_ch, chdat(tbl[v].fp_ch), 1'b1);
    end

    // T5: load DEADBEEF from ch0 (rr ptr 3 -> scan 3,0), then stall 3 cycles
    @(negedge clk);
    in_data[0 +: WIDTH] = 64'hDEAD_BEEF;
    in_valid  = 4'h1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_out("T5 load", 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b0);
    chk_out("T5 load", 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid  = 4'hF;
      out_ready = 1'b0;
      #1;
      check($sformatf("T5 stall%0d rr in_ready", c), 64'(rr_in_ready), 64'h0);
      check($sformatf("T5 stall%0d fp in_ready", c), 64'(fp_in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk_out($sformatf("T5 stall%0d", c), 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b0);
      chk_out($sformatf("T5 stall%0d", c), 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b1);
    end
    @(negedge clk);
    in_valid  = 4'h4;
    out_ready = 1'b1;
    #1;
    check("T5 refill rr in_ready", 64'(rr_in_ready), 64'h4);
    check("T5 refill fp in_ready", 64'(fp_in_ready), 64'h4);
    @(posedge clk);
    #1;
    chk_out("T5 refill", 1'b1, 2'd2, 64'hA2, 1'b0);
    chk_out("T5 refill", 1'b1, 2'd2, 64'hA2, 1'b1);

    // T1: asynchronous reset away from any clock edge while a beat is held
    @(negedge clk);
    in_valid = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    check("T1 rr in_ready", 64'(rr_in_ready), 64'h0);
    check("T1 fp in_ready", 64'(fp_in_ready), 64'h0);
    chk_out("T1 async", 1'b0, 2'd0, 64'h0, 1'b0);
    chk_out("T1 async", 1'b0, 2'd0, 64'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("T1 post rr in_ready ptr0", 64'(rr_in_ready), 64'h1);
    @(posedge clk);
    #1;
    chk_out("T1 post", 1'b1, 2'd0, 64'hDEAD_BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
